// File: rtl/rst_sequencer.sv
// Reset sequencer: filters PLL locks, stretches reset, then releases the domain resets one at a time.
// state   | meaning
// HOLD    | waiting for all locks to stay high for LOCK_FILTER cycles
// STRETCH | locks are stable; holding every domain in reset for STRETCH cycles
// RELEASE | releasing domains in order, STAGE_GAP cycles apart
// RUN     | every domain is released
module rst_sequencer #(
   parameter int NUM_PLL     = 3,
   parameter int NUM_DOM     = 4,
   parameter int LOCK_FILTER = 8,
   parameter int STRETCH     = 25,
   parameter int STAGE_GAP   = 16
) (
   input  logic               o_sys_clk,
   input  logic               rst_tmp,
   input  logic [NUM_PLL-1:0] i_pll_locked,
   input  logic               i_sw_rst,
   input  logic               i_clr_sticky,
   output logic [NUM_DOM-1:0] o_dom_rst,
   output logic               o_all_released,
   output logic [1:0]         o_state,
   output logic [7:0]         o_lock_loss_cnt,
   output logic [NUM_PLL-1:0] o_lock_lost_sticky
);

   localparam int MAX_AB = (LOCK_FILTER > STRETCH) ? LOCK_FILTER : STRETCH;
   localparam int MAX_C  = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
   localparam int CW     = $clog2(MAX_C) + 1;
   localparam int IW     = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   localparam logic [CW-1:0] FILT_TC = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] STR_TC  = CW'(STRETCH - 1);
   localparam logic [CW-1:0] GAP_TC  = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_END = IW'((NUM_DOM > 1) ? (NUM_DOM - 2) : 0);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_STRETCH = 2'd1,
      S_RELEASE = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [IW-1:0]        r_idx;
   logic [IW-1:0]        w_idx_nxt;
   logic [NUM_PLL-1:0]   r_sync1;
   logic [NUM_PLL-1:0]   r_lk_s;
   logic [NUM_PLL-1:0]   r_lk_d;
   logic [7:0]           r_loss_cnt;
   logic [NUM_PLL-1:0]   r_sticky;
   logic                 w_all_lk;
   logic                 w_go;
   logic                 w_loss_evt;
   logic [NUM_PLL-1:0]   w_fall;

   always_ff @(posedge o_sys_clk or posedge rst_tmp) begin
      if (rst_tmp) begin
         r_sync1 <= '0;
         r_lk_s  <= '0;
         r_lk_d  <= '0;
      end else begin
         r_sync1 <= i_pll_locked;
         r_lk_s  <= r_sync1;
         r_lk_d  <= r_lk_s;
      end
   end

   assign w_all_lk   = &r_lk_s;
   assign w_go       = w_all_lk & ~i_sw_rst;
   assign w_fall     = r_lk_d & ~r_lk_s;
   assign w_loss_evt = (r_state != S_HOLD) & ~w_all_lk;

   always_ff @(posedge o_sys_clk or posedge rst_tmp) begin
      if (rst_tmp) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Any lock drop or software request outside HOLD wins over a release due on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      if (r_state != S_HOLD && !w_go) begin
         w_state_nxt = S_HOLD;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (!w_go) begin
                  w_cnt_nxt = '0;
               end else if (r_cnt == FILT_TC) begin
                  w_state_nxt = S_STRETCH;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_STRETCH: begin
               if (r_cnt == STR_TC) begin
                  w_state_nxt = (NUM_DOM == 1) ? S_RUN : S_RELEASE;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (r_cnt == GAP_TC) begin
                  w_cnt_nxt = '0;
                  if (r_idx == IDX_END) begin
                     w_state_nxt = S_RUN;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_RUN: begin
               w_cnt_nxt = '0;
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      o_dom_rst      = '1;
      o_all_released = 1'b0;
      case (r_state)
         S_RELEASE: begin
            for (int i = 0; i < NUM_DOM; i++) begin
               o_dom_rst[i] = (i > int'(r_idx));
            end
         end
         S_RUN: begin
            o_dom_rst      = '0;
            o_all_released = 1'b1;
         end
         default: begin
            o_dom_rst      = '1;
            o_all_released = 1'b0;
         end
      endcase
   end

   assign o_state = r_state;

   always_ff @(posedge o_sys_clk or posedge rst_tmp) begin
      if (rst_tmp) begin
         r_loss_cnt <= '0;
         r_sticky   <= '0;
      end else begin
         if (w_loss_evt && r_loss_cnt != 8'hFF) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
         end
         r_sticky <= (r_sticky & ~{NUM_PLL{i_clr_sticky}}) | w_fall;
      end
   end

   assign o_lock_loss_cnt    = r_loss_cnt;
   assign o_lock_lost_sticky = r_sticky;

endmodule
